// File: rtl/data_mem_arbiter.sv
// Data memory port arbiter. The core load/store path and a debug/loader master
// share one Data_Memory port.
// - Ties are broken round-robin.
// - The debug master may hold a bounded exclusive burst (lock).
// - Read data is registered and returned to whichever master issued the read.
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    // core master
    input  logic                  core_req_i,
    input  logic                  core_we_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_i,
    output logic                  core_gnt_o,
    output logic                  core_stall_o,
    output logic                  core_rvalid_o,
    output logic [DATA_WIDTH-1:0] core_rdata_o,
    // debug master
    input  logic                  dbg_req_i,
    input  logic                  dbg_we_i,
    input  logic                  dbg_lock_i,
    input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
    input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
    output logic                  dbg_gnt_o,
    output logic                  dbg_rvalid_o,
    output logic [DATA_WIDTH-1:0] dbg_rdata_o,
    // memory side
    output logic                  mem_write_o,
    output logic                  mem_read_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                last_winner_q, last_winner_d;   // 0 = core, 1 = dbg
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

    logic                core_rvalid_q, core_rvalid_d;
    logic [DATA_WIDTH-1:0] core_rdata_q, core_rdata_d;
    logic                dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

    logic                lock_hold;
    logic                core_gnt;
    logic                dbg_gnt;

    // Burst still owns the port: locked, debug still asks for it, budget left.
    assign lock_hold = (state_q == LOCK) && dbg_lock_i &&
                       (beat_cnt_q < CNT_W'(MAX_BURST));

    // State register and registered read responses; everything cleared in reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ARB;
            last_winner_q <= 1'b1;
            beat_cnt_q    <= '0;
            core_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
            dbg_rvalid_q  <= 1'b0;
            dbg_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            beat_cnt_q    <= beat_cnt_d;
            core_rvalid_q <= core_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            dbg_rdata_q   <= dbg_rdata_d;
        end
    end

    // Grant decision: at most one master per cycle, nothing while in reset.
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (reset) begin
            if (lock_hold) begin
                // The core stalls even if debug has nothing to issue this cycle.
                dbg_gnt = dbg_req_i;
            end else if (state_q == LOCK) begin
                // Release cycle: the core gets the first shot after a burst.
                core_gnt = core_req_i;
                dbg_gnt  = dbg_req_i & ~core_req_i;
            end else if (core_req_i && dbg_req_i) begin
                // Tie: the loser of the previous grant goes next.
                core_gnt = last_winner_q;
                dbg_gnt  = ~last_winner_q;
            end else begin
                core_gnt = core_req_i;
                dbg_gnt  = dbg_req_i;
            end
        end
    end

    // Next-state logic: lock entry and exit, beat counting, round-robin history.
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        last_winner_d = last_winner_q;

        if (core_gnt) begin
            last_winner_d = 1'b0;
        end else if (dbg_gnt) begin
            last_winner_d = 1'b1;
        end

        if (lock_hold) begin
            if (dbg_gnt) begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end else if (dbg_gnt && dbg_lock_i) begin
            // A locked debug win from ARB or from a release cycle opens a new burst.
            state_d    = LOCK;
            beat_cnt_d = CNT_W'(1);
        end else begin
            state_d    = ARB;
            beat_cnt_d = '0;
        end
    end

    // Capture read data for the master whose read was issued this cycle.
    always_comb begin
        core_rvalid_d = core_gnt & ~core_we_i;
        dbg_rvalid_d  = dbg_gnt & ~dbg_we_i;
        core_rdata_d  = core_rvalid_d ? mem_rdata_i : core_rdata_q;
        dbg_rdata_d   = dbg_rvalid_d ? mem_rdata_i : dbg_rdata_q;
    end

    // Output drive: memory-side mux from the winner, zeros when idle.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        if (core_gnt) begin
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
            mem_write_o = core_we_i;
            mem_read_o  = ~core_we_i;
        end else if (dbg_gnt) begin
            mem_addr_o  = dbg_addr_i;
            mem_wdata_o = dbg_wdata_i;
            mem_write_o = dbg_we_i;
            mem_read_o  = ~dbg_we_i;
        end
    end

    assign core_gnt_o    = core_gnt;
    assign dbg_gnt_o     = dbg_gnt;
    assign core_stall_o  = core_req_i & ~core_gnt;
    assign core_rvalid_o = core_rvalid_q;
    assign core_rdata_o  = core_rdata_q;
    assign dbg_rvalid_o  = dbg_rvalid_q;
    assign dbg_rdata_o   = dbg_rdata_q;

endmodule
